// File: rtl/bus_decode_pkg.sv
// Shared types and helpers for the serial bus address decoders.
package bus_decode_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SELECTED
  } dec_state_t;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_TAG_WIDTH  = 4;

  // Upper bounds that let one helper serve every decoder configuration.
  localparam int unsigned MAX_TARGETS   = 8;
  localparam int unsigned MAX_TAG_WIDTH = 8;

  typedef logic [MAX_TARGETS*MAX_TAG_WIDTH-1:0] tag_table_t;
  typedef logic [MAX_TAG_WIDTH-1:0]             tag_t;

  // True when slice idx (tw bits wide) of the packed tag table equals tag.
  function automatic logic tag_match(input tag_table_t  tags,
                                     input int unsigned idx,
                                     input tag_t        tag,
                                     input int unsigned tw);
    tag_t slice;
    tag_t mask;
    slice = tag_t'(tags >> (idx * tw));
    mask  = ~(tag_t'('1) << tw);
    return ((slice ^ tag) & mask) == '0;
  endfunction

endpackage

// File: rtl/serial_addr_shifter.sv
// LSB-first address deserialiser with bit counter and complete/short-frame flags.
module serial_addr_shifter
  import bus_decode_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TAG_WIDTH  = DEF_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 shift_en,
  input  logic                 clear,
  input  logic                 bit_in,
  input  logic                 mode,
  output logic [TAG_WIDTH-1:0] addr_tag,
  output logic                 full,
  output logic                 short_frame
);

  localparam int unsigned CNT_W = $clog2(ADDR_WIDTH + 1);

  logic [ADDR_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      cnt;

  assign full        = (cnt == CNT_W'(ADDR_WIDTH));
  assign short_frame = !mode && (cnt != '0) && !full;
  assign addr_tag    = shift_reg[ADDR_WIDTH-1 -: TAG_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      cnt       <= '0;
    end else if (start) begin
      // Zero the stale tail so an aborted frame can never leak into the next one.
      shift_reg <= {bit_in, {(ADDR_WIDTH-1){1'b0}}};
      cnt       <= CNT_W'(1);
    end else if (clear) begin
      cnt <= '0;
    end else if (shift_en && !full) begin
      shift_reg <= ADDR_WIDTH'({bit_in, shift_reg} >> 1);
      cnt       <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/addr_decoder_n.sv
// N-target serial address decoder with single outstanding split tracking.
// Optional: DECODER_DEFAULT_TARGET_EN routes unmatched addresses to DEFAULT_TARGET.
module addr_decoder_n
  import bus_decode_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_TARGETS    = 3,
  parameter int unsigned TAG_WIDTH      = DEF_TAG_WIDTH,
  parameter logic [NUM_TARGETS*TAG_WIDTH-1:0] TARGET_TAGS = {4'h8, 4'h4, 4'h0},
  parameter int unsigned DEFAULT_TARGET = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           bus_data_in,
  input  logic                           bus_data_in_valid,
  input  logic                           bus_mode,
  input  logic                           split,
  output logic [NUM_TARGETS-1:0]         target_valid,
  output logic [$clog2(NUM_TARGETS)-1:0] sel,
  output logic                           decode_error,
  output logic                           frame_error,
  output logic                           split_pending
);

  localparam int unsigned SEL_W = $clog2(NUM_TARGETS);
  localparam tag_table_t TAGS_EXT = tag_table_t'(TARGET_TAGS);
  localparam logic [SEL_W-1:0] DEF_IDX =
    SEL_W'((DEFAULT_TARGET < NUM_TARGETS) ? DEFAULT_TARGET : 0);
`ifdef DECODER_DEFAULT_TARGET_EN
  localparam bit DEF_EN = 1'b1;
`else
  localparam bit DEF_EN = 1'b0;
`endif

  dec_state_t           state;
  logic [SEL_W-1:0]     owner;
  logic                 split_q;
  logic                 hold;
  logic [TAG_WIDTH-1:0] addr_tag;
  logic                 addr_full;
  logic                 short_frame;
  logic                 hit;
  logic [SEL_W-1:0]     hit_idx;
  logic                 restore;
  logic                 park;
  logic                 start;
  logic                 shift_en;
  logic                 sh_clear;

  // hold suppresses re-decode on surplus address bits until bus_mode drops.
  assign restore  = !split && split_q && split_pending;
  assign park     = split && !split_q && (state == SELECTED) && !restore;
  assign start    = !restore && !park && (state != SHIFT) &&
                    bus_mode && bus_data_in_valid && !hold;
  assign shift_en = (state == SHIFT) && bus_mode && bus_data_in_valid;
  assign sh_clear = restore || ((state == SHIFT) && (addr_full || short_frame));

  serial_addr_shifter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .shift_en    (shift_en),
    .clear       (sh_clear),
    .bit_in      (bus_data_in),
    .mode        (bus_mode),
    .addr_tag    (addr_tag),
    .full        (addr_full),
    .short_frame (short_frame)
  );

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (!hit && tag_match(TAGS_EXT, i, tag_t'(addr_tag), TAG_WIDTH)) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      target_valid  <= '0;
      sel           <= '0;
      decode_error  <= 1'b0;
      frame_error   <= 1'b0;
      split_pending <= 1'b0;
      owner         <= '0;
      split_q       <= 1'b0;
      hold          <= 1'b0;
    end else begin
      decode_error <= 1'b0;
      frame_error  <= 1'b0;
      split_q      <= split;
      hold         <= hold & bus_mode;
      if (restore) begin
        target_valid  <= NUM_TARGETS'(1) << owner;
        sel           <= owner;
        split_pending <= 1'b0;
        state         <= SELECTED;
        hold          <= bus_mode;
      end else if (park) begin
        owner         <= sel;
        split_pending <= 1'b1;
        target_valid  <= '0;
        state         <= IDLE;
        hold          <= bus_mode;
      end else if (start) begin
        target_valid <= '0;
        state        <= SHIFT;
      end else if (state == SHIFT) begin
        if (addr_full) begin
          hold <= bus_mode;
          if (hit) begin
            target_valid <= NUM_TARGETS'(1) << hit_idx;
            sel          <= hit_idx;
            state        <= SELECTED;
          end else if (DEF_EN) begin
            target_valid <= NUM_TARGETS'(1) << DEF_IDX;
            sel          <= DEF_IDX;
            state        <= SELECTED;
          end else begin
            decode_error <= 1'b1;
            state        <= IDLE;
          end
        end else if (short_frame) begin
          frame_error <= 1'b1;
          state       <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_addr_decoder_n.sv
// Directed bench for addr_decoder_n: vector table plus split/frame/reset sequences.
module tb_addr_decoder_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bus_data_in;
  logic       bus_data_in_valid;
  logic       bus_mode;
  logic       split;
  logic [2:0] target_valid;
  logic [1:0] sel;
  logic       decode_error;
  logic       frame_error;
  logic       split_pending;

  int errors = 0;
  int checks = 0;

`ifdef DECODER_DEFAULT_TARGET_EN
  localparam bit DEF_EN = 1'b1;
`else
  localparam bit DEF_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] addr;
    int          stalls;
    logic [2:0]  exp_tv;
    logic [1:0]  exp_sel;
    logic        exp_derr;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  addr_decoder_n #(
    .ADDR_WIDTH     (16),
    .NUM_TARGETS    (3),
    .TAG_WIDTH      (4),
    .TARGET_TAGS    (12'h840),
    .DEFAULT_TARGET (0)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus_data_in       (bus_data_in),
    .bus_data_in_valid (bus_data_in_valid),
    .bus_mode          (bus_mode),
    .split             (split),
    .target_valid      (target_valid),
    .sel               (sel),
    .decode_error      (decode_error),
    .frame_error       (frame_error),
    .split_pending     (split_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic b, input logic v);
    @(negedge clk);
    bus_mode          = 1'b1;
    bus_data_in_valid = v;
    bus_data_in       = b;
  endtask

  task automatic idle();
    @(negedge clk);
    bus_mode          = 1'b0;
    bus_data_in_valid = 1'b0;
    bus_data_in       = 1'b0;
  endtask

  task automatic data_cycle(input logic b);
    @(negedge clk);
    bus_mode          = 1'b0;
    bus_data_in_valid = 1'b1;
    bus_data_in       = b;
  endtask

  task automatic send_addr(input logic [15:0] a, input int stalls);
    for (int i = 0; i < 16; i++) begin
      drive_bit(a[i], 1'b1);
      if (i == 7)
        for (int s = 0; s < stalls; s++) drive_bit(1'b1, 1'b0);
    end
  endtask

  task automatic set_split(input logic v);
    @(negedge clk);
    bus_mode          = 1'b0;
    bus_data_in_valid = 1'b0;
    split             = v;
  endtask

  initial begin
    vecs[0] = '{16'h800A, 0, 3'b100, 2'd2, 1'b0};
    vecs[1] = '{16'h4123, 2, 3'b010, 2'd1, 1'b0};
    vecs[2] = '{16'hF000, 0, DEF_EN ? 3'b001 : 3'b000, DEF_EN ? 2'd0 : 2'd1, !DEF_EN};
    vecs[3] = '{16'h0FFF, 0, 3'b001, 2'd0, 1'b0};
    vecs[4] = '{16'h4000, 3, 3'b010, 2'd1, 1'b0};
    vecs[5] = '{16'h8F44, 0, 3'b100, 2'd2, 1'b0};
    vecs[6] = '{16'h7FFF, 0, DEF_EN ? 3'b001 : 3'b000, DEF_EN ? 2'd0 : 2'd2, !DEF_EN};
    vecs[7] = '{16'h0010, 1, 3'b001, 2'd0, 1'b0};

    rst_n = 1'b0; bus_data_in = 1'b0; bus_data_in_valid = 1'b0;
    bus_mode = 1'b0; split = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tv", target_valid, 0);
    check("rst_sel", sel, 0);
    check("rst_derr", decode_error, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_pend", split_pending, 0);
    rst_n = 1'b1;
    idle();

    foreach (vecs[k]) begin
      send_addr(vecs[k].addr, vecs[k].stalls);
      idle();
      check($sformatf("v%0d_latency_tv", k), target_valid, 0);
      data_cycle(1'b1);
      check($sformatf("v%0d_tv", k), target_valid, vecs[k].exp_tv);
      check($sformatf("v%0d_sel", k), sel, vecs[k].exp_sel);
      check($sformatf("v%0d_derr", k), decode_error, vecs[k].exp_derr);
      data_cycle(1'b0);
      check($sformatf("v%0d_derr_clr", k), decode_error, 0);
      check($sformatf("v%0d_tv_hold", k), target_valid, vecs[k].exp_tv);
      idle();
    end

    // short frame, then a full address recovers
    for (int i = 0; i < 8; i++) drive_bit(i[0], 1'b1);
    idle();
    idle();
    check("frame_err", frame_error, 1);
    check("frame_tv", target_valid, 0);
    idle();
    check("frame_err_clr", frame_error, 0);
    send_addr(16'h8F44, 0);
    idle();
    idle();
    check("post_frame_tv", target_valid, 3'b100);
    check("post_frame_sel", sel, 2);

    // split park, another initiator decodes, split release restores owner
    set_split(1'b1);
    idle();
    check("park_tv", target_valid, 0);
    check("park_pend", split_pending, 1);
    send_addr(16'h0010, 0);
    idle();
    idle();
    check("other_tv", target_valid, 3'b001);
    check("other_pend", split_pending, 1);
    set_split(1'b0);
    idle();
    check("restore_tv", target_valid, 3'b100);
    check("restore_sel", sel, 2);
    check("restore_pend", split_pending, 0);

    // split fall coincides with final address bit: restore wins
    set_split(1'b1);
    idle();
    check("park2_pend", split_pending, 1);
    for (int i = 0; i < 15; i++) drive_bit(i == 4, 1'b1);
    drive_bit(1'b0, 1'b1);
    split = 1'b0;
    idle();
    check("race_tv", target_valid, 3'b100);
    check("race_sel", sel, 2);
    check("race_pend", split_pending, 0);
    idle();
    check("race_tv_hold", target_valid, 3'b100);
    check("race_ferr", frame_error, 0);
    check("race_derr", decode_error, 0);

    // surplus address bits are ignored
    send_addr(16'h4123, 0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1);
    idle();
    idle();
    check("extra_tv", target_valid, 3'b010);
    check("extra_sel", sel, 1);
    check("extra_derr", decode_error, 0);

    // async reset mid-shift with a split owner recorded
    set_split(1'b1);
    idle();
    check("pre_rst_pend", split_pending, 1);
    check("pre_rst_sel", sel, 1);
    for (int i = 0; i < 10; i++) drive_bit(1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tv", target_valid, 0);
    check("mid_rst_sel", sel, 0);
    check("mid_rst_pend", split_pending, 0);
    check("mid_rst_ferr", frame_error, 0);
    split = 1'b0; bus_mode = 1'b0; bus_data_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    send_addr(16'h800A, 0);
    idle();
    idle();
    check("post_rst_tv", target_valid, 3'b100);
    check("post_rst_sel", sel, 2);
    check("post_rst_derr", decode_error, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
